// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB requester and APB responders.
//   APB_ADDR_W / APB_DATA_W : APB address and data widths
//   apb_state_e             : transfer phase (IDLE, SETUP, ACCESS, RESP)
//   cnt_width()             : width of a counter that must hold 0..limit
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // A limit of 0 still needs one bit so the counter signal exists.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_requester.sv
// apb_requester: turns single commands into APB transfers, one at a time.
//   clk, n_rst                      : clock (rising edge), async active-low reset
//   req_valid/req_ready             : command handshake; req_addr/wdata/write sampled at accept
//   rsp_valid/rsp_ready             : response handshake; rsp_rdata/rsp_error held while valid
//   paddr/pwdata/pwrite/psel/penable: APB requester outputs, all registered
//   prdata/pready                   : APB responder inputs, only looked at in ACCESS
//
// state  | meaning
// IDLE   | waiting for a command, req_ready high
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
// RESP   | rsp_valid=1 until rsp_ready
module apb_requester
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic                  req_write,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  // Counter value during the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e            state_q, state_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_hit;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    cnt_d       = cnt_q;
    timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
          pwrite_d  = req_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready is tested first so a completion on the limit cycle wins.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          // Stops at TIMEOUT_CYCLES, which the counter width can hold.
          if (TO_EN) cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed transfers against apb_requester with TIMEOUT_CYCLES=4.
// The stimulus pushes each expected response into a queue; a monitor pops and
// compares whenever a response handshake is about to complete.
module tb_apb_requester;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_write = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [15:0] paddr;
  logic [7:0]  pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [7:0]  prdata = '0;
  logic        pready = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_issued = 0;
  int n_rsp = 0;
  logic [8:0] sb_q[$];  // {error, rdata}

  apb_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: rsp_valid && rsp_ready seen mid-cycle means the handshake completes at the next edge.
  always @(negedge clk) begin
    if (n_rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h err %0d with no response expected", rsp_rdata, rsp_error);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[7:0]);
        chk("rsp_error", rsp_error, e[8]);
      end
    end
  end

  // One full transfer. waits = ACCESS cycles with pready low before pready high;
  // waits >= TO means the responder never answers. rsp_delay = cycles rsp_ready stays low.
  task automatic do_txn(input logic [15:0] addr, input logic [7:0] wdata, input logic wr,
                        input int waits, input logic [7:0] sdata, input int rsp_delay);
    logic       to;
    logic [7:0] er;
    int         nacc;
    to   = (waits >= TO);
    er   = (wr || to) ? 8'h00 : sdata;
    nacc = to ? TO : waits + 1;
    sb_q.push_back({to, er});
    n_issued++;

    // cycle N: offer the command
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_write = wr; rsp_ready = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);

    // cycle N+1: SETUP; scrambled command fields and a stray pready must not matter
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_write = ~wr;
    pready = 1'b1; prdata = 8'hEE;
    @(negedge clk);
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwdata", pwdata, wdata);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_req_ready", req_ready, 0);

    // ACCESS cycles
    for (int i = 0; i < nacc; i++) begin
      @(posedge clk); #1;
      pready = (!to && i == waits);
      prdata = pready ? sdata : 8'h77;
      @(negedge clk);
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, addr);
      chk("access_pwdata", pwdata, wdata);
      chk("access_pwrite", pwrite, wr);
    end

    // RESP cycles; during backpressure a new command is offered and must be ignored
    for (int k = 0; k <= rsp_delay; k++) begin
      @(posedge clk); #1;
      pready = 1'b1; prdata = 8'hEE;
      rsp_ready = (k == rsp_delay);
      req_valid = (k != rsp_delay);
      @(negedge clk);
      chk("resp_psel", psel, 0);
      chk("resp_penable", penable, 0);
      chk("resp_valid", rsp_valid, 1);
      chk("resp_rdata_hold", rsp_rdata, er);
      chk("resp_error_hold", rsp_error, to);
      chk("resp_req_ready", req_ready, 0);
    end

    @(posedge clk); #1;
    pready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_req_ready", req_ready, 1);
    chk("done_psel", psel, 0);
    chk("done_rdata_kept", rsp_rdata, er);
    chk("done_error_kept", rsp_error, to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);

    do_txn(16'h0102, 8'h00, 1'b0, 0,  8'h5A, 0);  // read, zero wait
    do_txn(16'h0200, 8'hC3, 1'b1, 3,  8'h99, 0);  // write, 3 waits (pready on limit cycle)
    do_txn(16'h1234, 8'h00, 1'b0, 2,  8'hA5, 0);  // read, 2 waits
    do_txn(16'h0040, 8'h11, 1'b0, 99, 8'h00, 0);  // timeout
    do_txn(16'h0041, 8'h00, 1'b0, 3,  8'h3C, 0);  // pready on the limit cycle, error cleared
    do_txn(16'h00FF, 8'h00, 1'b0, 1,  8'h81, 5);  // response backpressure
    do_txn(16'hBEEF, 8'h5C, 1'b1, 0,  8'h42, 0);  // write, zero wait

    // reset in the middle of ACCESS: no response may follow
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 16'h0A0A; req_wdata = 8'h00; req_write = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; pready = 1'b0;
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
      chk("midrst_no_psel", psel, 0);
    end

    do_txn(16'h0303, 8'h00, 1'b0, 0, 8'hC9, 0);   // normal operation after reset

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    chk("rsp_count", n_rsp, n_issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS-phase cycles before abort; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port n_rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: a command is offered.
REQ-005 SHALL have port req_ready, output, 1: the command is accepted when req_valid and req_ready are both high.
REQ-006 SHALL have ports req_addr (input, 16), req_wdata (input, 8) and req_write (input, 1): command fields, sampled at acceptance.
REQ-007 SHALL have port rsp_valid, output, 1: a response is presented.
REQ-008 SHALL have port rsp_ready, input, 1: the response is consumed when rsp_valid and rsp_ready are both high.
REQ-009 SHALL have ports rsp_rdata (output, 8) and rsp_error (output, 1): read data and timeout flag.
REQ-010 SHALL have APB requester ports paddr (output, 16), pwdata (output, 8), pwrite (output, 1), psel (output, 1), penable (output, 1), prdata (input, 8) and pready (input, 1).

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-012 SHALL assert req_ready only in IDLE, so at most one transaction is outstanding.
REQ-013 IDLE, on acceptance: SHALL capture addr, wdata and write into paddr, pwdata and pwrite, then go to SETUP.
REQ-014 SETUP: SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-015 ACCESS: SHALL drive psel=1 and penable=1 until pready is sampled high or the transaction times out.
REQ-016 SHALL hold paddr, pwdata and pwrite stable from SETUP through the last ACCESS cycle.
REQ-017 SHALL hold psel and penable at 0 in IDLE and RESP.
REQ-018 On pready=1 in ACCESS: SHALL load rsp_rdata with prdata for a read (0x00 for a write), clear rsp_error, and go to RESP.
REQ-019 Timeout: SHALL clear the wait counter on entry to ACCESS and increment it on each ACCESS cycle with pready=0.
REQ-020 On the counter reaching TIMEOUT_CYCLES (when TIMEOUT_CYCLES is nonzero): SHALL set rsp_error=1 and rsp_rdata=0x00, drop psel and penable, and go to RESP.
REQ-021 SHALL size the counter at clog2(TIMEOUT_CYCLES+1) bits, with no wrap-around possible.
REQ-022 SHALL give pready precedence over timeout when both occur in the same cycle.
REQ-023 RESP: SHALL hold rsp_valid=1 with rsp_rdata and rsp_error stable until rsp_ready is sampled high, then go to IDLE.
REQ-024 SHALL keep rsp_rdata and rsp_error unchanged outside RESP; rsp_valid SHALL be 0 outside RESP.
REQ-025 With zero wait states, latency SHALL be: accept at cycle N, psel at N+1, penable at N+2, rsp_valid at N+3.
REQ-026 Back-to-back throughput SHALL be one transaction per 4 cycles minimum.
REQ-027 SHALL ignore prdata and pready outside ACCESS.

Reset
REQ-028 On n_rst low, asynchronously: state SHALL go to IDLE, and psel, penable, pwrite, rsp_valid and rsp_error SHALL go to 0.
REQ-029 On n_rst low: paddr, pwdata, rsp_rdata and the counter SHALL go to 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction without a response; psel SHALL drop immediately.
REQ-031 Reset deassertion SHALL be synchronised externally; req_ready SHALL be 1 in the first cycle after release.

Structure
REQ-032 SHALL place the state enum (IDLE, SETUP, ACCESS, RESP), APB_ADDR_W=16 and APB_DATA_W=8 in shared package apb_pkg, for reuse by the APB responders.
REQ-033 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-034 Read, zero wait: req addr=0x0102, write=0; responder pready=1, prdata=0x5A -> psel at N+1, penable at N+2, rsp_valid at N+3, rsp_rdata=0x5A, rsp_error=0.
REQ-035 Write, 3 wait states: addr=0x0200, wdata=0xC3 -> paddr, pwdata and pwrite=1 stable for 4 ACCESS cycles; rsp_rdata=0x00, rsp_error=0.
REQ-036 Timeout, TIMEOUT_CYCLES=4, pready held 0 -> after 4 ACCESS cycles psel drops, rsp_error=1, rsp_rdata=0x00.
REQ-037 Response backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 and new req_valid ignored throughout; completes the cycle after rsp_ready rises.
REQ-038 Reset mid-ACCESS: n_rst pulsed low during ACCESS -> psel, penable and rsp_valid are 0 immediately; req_ready=1 after release; no stale response appears.
REQ-039 Simultaneous pready and timeout at the limit cycle -> normal completion, rsp_error=0.
